// File: rtl/stos_pkg.sv
// Shared types and constants for the two-requester stack arbiter.
// Holds the FSM state enum, op encodings and default sizes.
package stos_pkg;

  localparam int STOS_DATA_W_DEF = 8;
  localparam int STOS_DEPTH_DEF  = 32;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    A_XFER,
    B_LO,
    B_HI,
    RESP
  } stos_state_t;

endpackage

// File: rtl/stos_arbiter_arb_rr2.sv
// Two-way round-robin grant with its own last-grant register.
// Ports: clk, rst, en (arbitrate this cycle), req_a/req_b in; gnt_a/gnt_b out.
module arb_rr2
  import stos_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (en) begin
      if (req_a && req_b) begin
        gnt_a = (last_q == GNT_B);
        gnt_b = (last_q == GNT_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Reset to B so A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_B;
    end else if (gnt_a) begin
      last_q <= GNT_A;
    end else if (gnt_b) begin
      last_q <= GNT_B;
    end
  end

endmodule

// File: rtl/stos_arbiter.sv
// Arbitrates a byte stack between a data unit (A, 1 byte) and a
// call/return unit (B, 2 bytes) with occupancy and sticky error tracking.
// Ports: clk, rst; a_req/a_op/a_data -> a_ack/a_rdata;
//   b_req/b_op/b_pc -> b_ack/b_rpc; st_push/st_pop/st_data_in -> stack,
//   st_data_out <- stack; err_ovf/err_unf/err_clr; busy; occ.
module stos_arbiter
  import stos_pkg::*;
#(
  parameter int STOS_data_rozm = STOS_DATA_W_DEF,
  parameter int STOS_Rozm      = STOS_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a_req,
  input  logic                          a_op,
  input  logic [STOS_data_rozm-1:0]     a_data,
  output logic                          a_ack,
  output logic [STOS_data_rozm-1:0]     a_rdata,
  input  logic                          b_req,
  input  logic                          b_op,
  input  logic [2*STOS_data_rozm-1:0]   b_pc,
  output logic                          b_ack,
  output logic [2*STOS_data_rozm-1:0]   b_rpc,
  output logic                          st_push,
  output logic                          st_pop,
  output logic [STOS_data_rozm-1:0]     st_data_in,
  input  logic [STOS_data_rozm-1:0]     st_data_out,
  output logic                          err_ovf,
  output logic                          err_unf,
  input  logic                          err_clr,
  output logic                          busy,
  output logic [$clog2(STOS_Rozm):0]    occ
);

  localparam int W  = STOS_data_rozm;
  localparam int OW = $clog2(STOS_Rozm) + 1;

  localparam logic [OW-1:0] DEPTH    = OW'(STOS_Rozm);
  localparam logic [OW-1:0] DEPTH_M2 = OW'(STOS_Rozm - 2);
  localparam logic [OW-1:0] ONE      = OW'(1);
  localparam logic [OW-1:0] TWO      = OW'(2);

  stos_state_t state_q, state_d;

  logic            who_q;
  logic            op_q;
  logic [2*W-1:0]  data_q;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    a_rdata_q;
  logic [2*W-1:0]  b_rpc_q;
  logic [OW-1:0]   occ_q;
  logic            ovf_q;
  logic            unf_q;

  logic            gnt_a;
  logic            gnt_b;
  logic            req_op;
  logic            feasible;
  logic            load;
  logic            set_ovf;
  logic            set_unf;

  arb_rr2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == IDLE),
    .req_a (a_req),
    .req_b (b_req),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // B moves two bytes, so it needs two free slots or two entries.
  always_comb begin
    req_op   = gnt_b ? b_op : a_op;
    feasible = 1'b0;
    unique case (1'b1)
      gnt_a && (a_op == OP_PUSH): feasible = (occ_q < DEPTH);
      gnt_a && (a_op == OP_POP):  feasible = (occ_q >= ONE);
      gnt_b && (b_op == OP_PUSH): feasible = (occ_q <= DEPTH_M2);
      gnt_b && (b_op == OP_POP):  feasible = (occ_q >= TWO);
      default:                    feasible = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    st_push    = 1'b0;
    st_pop     = 1'b0;
    st_data_in = '0;
    load       = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_a || gnt_b) begin
          load = 1'b1;
          if (!feasible) begin
            set_ovf = (req_op == OP_PUSH);
            set_unf = (req_op == OP_POP);
            state_d = RESP;
          end else if (gnt_a) begin
            state_d = A_XFER;
          end else begin
            state_d = B_LO;
          end
        end
      end
      A_XFER: begin
        st_push    = (op_q == OP_PUSH);
        st_pop     = (op_q == OP_POP);
        st_data_in = data_q[W-1:0];
        state_d    = RESP;
      end
      B_LO: begin
        st_push    = (op_q == OP_PUSH);
        st_pop     = (op_q == OP_POP);
        st_data_in = data_q[W-1:0];
        state_d    = B_HI;
      end
      B_HI: begin
        st_push    = (op_q == OP_PUSH);
        st_pop     = (op_q == OP_POP);
        st_data_in = data_q[2*W-1:W];
        state_d    = RESP;
      end
      RESP: begin
        a_ack   = (who_q == GNT_A);
        b_ack   = (who_q == GNT_B);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request is captured at grant so later input changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      who_q     <= GNT_A;
      op_q      <= OP_PUSH;
      data_q    <= '0;
      hi_q      <= '0;
      a_rdata_q <= '0;
      b_rpc_q   <= '0;
    end else begin
      if (load) begin
        who_q  <= gnt_b;
        op_q   <= req_op;
        data_q <= gnt_b ? b_pc : {{W{1'b0}}, a_data};
      end
      if (state_q == A_XFER && op_q == OP_POP) begin
        a_rdata_q <= st_data_out;
      end
      // High byte comes off first; b_rpc only changes once complete.
      if (state_q == B_LO && op_q == OP_POP) begin
        hi_q <= st_data_out;
      end
      if (state_q == B_HI && op_q == OP_POP) begin
        b_rpc_q <= {hi_q, st_data_out};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (st_push && occ_q != DEPTH) begin
      occ_q <= occ_q + ONE;
    end else if (st_pop && occ_q != '0) begin
      occ_q <= occ_q - ONE;
    end
  end

  // A new error wins over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (set_ovf) begin
        ovf_q <= 1'b1;
      end else if (err_clr) begin
        ovf_q <= 1'b0;
      end
      if (set_unf) begin
        unf_q <= 1'b1;
      end else if (err_clr) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rpc   = b_rpc_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;
  assign occ     = occ_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_stos_arbiter.sv
// Self-checking bench for stos_arbiter with an attached byte stack.
// Directed scenarios followed by randomized single and tied requests.
module tb_stos_arbiter;

  localparam int W = 8;
  localparam int D = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_op;
  logic [W-1:0]  a_data;
  logic          a_ack;
  logic [W-1:0]  a_rdata;
  logic          b_req, b_op;
  logic [2*W-1:0] b_pc;
  logic          b_ack;
  logic [2*W-1:0] b_rpc;
  logic          st_push, st_pop;
  logic [W-1:0]  st_data_in;
  logic [W-1:0]  st_data_out;
  logic          err_ovf, err_unf, err_clr;
  logic          busy;
  logic [5:0]    occ;

  stos_arbiter #(.STOS_data_rozm(W), .STOS_Rozm(D)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_op(a_op), .a_data(a_data),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_op(b_op), .b_pc(b_pc),
    .b_ack(b_ack), .b_rpc(b_rpc),
    .st_push(st_push), .st_pop(st_pop),
    .st_data_in(st_data_in), .st_data_out(st_data_out),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr),
    .busy(busy), .occ(occ)
  );

  always #5 clk = ~clk;

  // Attached stack: plain array plus pointer, cleared by the shared reset.
  logic [W-1:0] mem [0:D-1];
  int sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
    end else if (st_push) begin
      mem[sp % D] <= st_data_in;
      sp <= sp + 1;
    end else if (st_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end
  always_comb begin
    st_data_out = '0;
    if (sp > 0) st_data_out = mem[(sp - 1) % D];
  end

  // Strobe log: {push, data}; pops are logged as 9'h000.
  logic [8:0] slog[$];
  bit both_seen = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      if (st_push) slog.push_back({1'b1, st_data_in});
      if (st_pop) slog.push_back(9'h000);
      if (st_push && st_pop) both_seen <= 1'b1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: stack as a queue of bytes, top at the back.
  logic [W-1:0]   ref_stk[$];
  bit             ref_ovf, ref_unf, ref_last;
  logic [W-1:0]   ref_ard;
  logic [2*W-1:0] ref_brpc;

  task automatic model_reset();
    ref_stk.delete();
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
    ref_last = 1'b1;
    ref_ard = '0;
    ref_brpc = '0;
  endtask

  function automatic int model_a(input bit op, input logic [W-1:0] d);
    ref_last = 1'b0;
    if (op == 1'b0) begin
      if (ref_stk.size() < D) begin
        ref_stk.push_back(d);
        return 2;
      end
      ref_ovf = 1'b1;
      return 1;
    end
    if (ref_stk.size() >= 1) begin
      ref_ard = ref_stk.pop_back();
      return 2;
    end
    ref_unf = 1'b1;
    return 1;
  endfunction

  function automatic int model_b(input bit op, input logic [2*W-1:0] pc);
    logic [W-1:0] hi, lo;
    ref_last = 1'b1;
    if (op == 1'b0) begin
      if (ref_stk.size() + 2 <= D) begin
        ref_stk.push_back(pc[W-1:0]);
        ref_stk.push_back(pc[2*W-1:W]);
        return 3;
      end
      ref_ovf = 1'b1;
      return 1;
    end
    if (ref_stk.size() >= 2) begin
      hi = ref_stk.pop_back();
      lo = ref_stk.pop_back();
      ref_brpc = {hi, lo};
      return 3;
    end
    ref_unf = 1'b1;
    return 1;
  endfunction

  // Issues A and/or B together from IDLE; ack cycles are counted from
  // the grant cycle of the first served requester.
  task automatic run_pair(input string tag,
                          input bit da, input bit aop, input logic [W-1:0] ad,
                          input bit db, input bit bop, input logic [2*W-1:0] bpc);
    int ea, eb, ca, cb, na, nb, cyc;
    bit b_first;
    ea = -1; eb = -1; ca = -1; cb = -1; na = 0; nb = 0; cyc = 0;
    b_first = db && (!da || ref_last == 1'b0);
    if (b_first) begin
      eb = model_b(bop, bpc);
      if (da) ea = eb + 1 + model_a(aop, ad);
    end else begin
      if (da) ea = model_a(aop, ad);
      if (db) eb = (da ? ea + 1 : 0) + model_b(bop, bpc);
    end
    a_req = da; a_op = aop; a_data = ad;
    b_req = db; b_op = bop; b_pc = bpc;
    while (((da && ca < 0) || (db && cb < 0)) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (a_ack) begin na++; if (ca < 0) ca = cyc; a_req = 1'b0; end
      if (b_ack) begin nb++; if (cb < 0) cb = cyc; b_req = 1'b0; end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk); #1;
    if (a_ack) na++;
    if (b_ack) nb++;
    if (da) chk({tag, "_a_lat"}, ca, ea);
    if (db) chk({tag, "_b_lat"}, cb, eb);
    chk({tag, "_a_acks"}, na, da);
    chk({tag, "_b_acks"}, nb, db);
    chk({tag, "_a_rdata"}, a_rdata, ref_ard);
    chk({tag, "_b_rpc"}, b_rpc, ref_brpc);
    chk({tag, "_occ"}, occ, ref_stk.size());
    chk({tag, "_ovf"}, err_ovf, ref_ovf);
    chk({tag, "_unf"}, err_unf, ref_unf);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
  endtask

  initial begin
    bit da, db, aop, bop;
    int pb;
    rst = 1'b1;
    a_req = 0; a_op = 0; a_data = '0;
    b_req = 0; b_op = 0; b_pc = '0;
    err_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_occ", occ, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {a_ack, b_ack}, 0);
    chk("rst_strobes", {st_push, st_pop}, 0);
    chk("rst_errs", {err_ovf, err_unf}, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rpc", b_rpc, 0);
    @(posedge clk); #1;

    run_pair("a_push5a", 1, 0, 8'h5A, 0, 0, '0);
    run_pair("a_pop5a", 1, 1, 8'h00, 0, 0, '0);
    chk("a_pop_val", a_rdata, 8'h5A);

    slog.delete();
    run_pair("b_push", 0, 0, '0, 1, 0, 16'h1234);
    chk("b_push_nstrobe", slog.size(), 2);
    chk("b_push_s0", slog.size() > 0 ? slog[0] : 9'h1FF, 9'h134);
    chk("b_push_s1", slog.size() > 1 ? slog[1] : 9'h1FF, 9'h112);
    slog.delete();
    run_pair("b_pop", 0, 0, '0, 1, 1, '0);
    chk("b_pop_nstrobe", slog.size(), 2);
    chk("b_pop_strobes", (slog.size() > 1) ? {slog[0], slog[1]} : 18'h3FFFF, 18'h0);
    chk("b_pop_val", b_rpc, 16'h1234);

    run_pair("tie1", 1, 0, 8'h11, 1, 0, 16'h2233);
    run_pair("a_only", 1, 0, 8'h44, 0, 0, '0);
    run_pair("tie2", 1, 0, 8'h55, 1, 0, 16'h6677);

    while (ref_stk.size() < 31) run_pair("fill", 1, 0, 8'($urandom), 0, 0, '0);
    slog.delete();
    run_pair("b_ovf", 0, 0, '0, 1, 0, 16'hBEEF);
    chk("b_ovf_nostrobe", slog.size(), 0);
    pulse_clr();
    chk("ovf_clr", err_ovf, 0);
    run_pair("a_fill32", 1, 0, 8'hC3, 0, 0, '0);
    run_pair("a_ovf", 1, 0, 8'hC4, 0, 0, '0);
    pulse_clr();

    while (ref_stk.size() >= 2) run_pair("drain_b", 0, 0, '0, 1, 1, '0);
    while (ref_stk.size() > 0) run_pair("drain_a", 1, 1, '0, 0, 0, '0);
    run_pair("a_unf", 1, 1, '0, 0, 0, '0);
    run_pair("b_unf", 0, 0, '0, 1, 1, '0);
    pulse_clr();
    chk("unf_clr", err_unf, 0);

    err_clr = 1'b1;
    a_req = 1'b1; a_op = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    ref_last = 1'b0;
    chk("unf_over_clr", err_unf, 1);
    chk("unf_over_clr_ack", a_ack, 1);
    a_req = 1'b0;
    @(posedge clk); #1;
    pulse_clr();

    run_pair("pre_rst", 1, 0, 8'h77, 0, 0, '0);
    b_req = 1'b1; b_op = 1'b0; b_pc = 16'hA1B2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_occ", occ, 0);
    chk("mid_rst_busy", busy, 0);
    #1 rst = 1'b0;
    b_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("post_rst_ack", b_ack, 0);
    @(posedge clk); #1;
    run_pair("post_rst_unf", 1, 1, '0, 0, 0, '0);
    pulse_clr();

    for (int i = 0; i < 160; i++) begin
      pb = (i < 80) ? 70 : 30;
      case ($urandom_range(0, 2))
        0: begin da = 1; db = 0; end
        1: begin da = 0; db = 1; end
        default: begin da = 1; db = 1; end
      endcase
      aop = ($urandom_range(0, 99) >= pb);
      bop = ($urandom_range(0, 99) >= pb);
      run_pair("rand", da, aop, 8'($urandom), db, bop, 16'($urandom));
      if (i % 17 == 16) pulse_clr();
    end

    chk("never_both_strobes", both_seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stos_arbiter.md
STOS_ARBITER -- requirements
Module: stos_arbiter

Interface
REQ-001 Parameter STOS_data_rozm, default 8, byte width of one stack entry.
REQ-002 Parameter STOS_Rozm, default 32, stack depth in entries; must equal the depth of the attached stack.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high; the same line also drives the attached stack.
REQ-005 a_req  in  1  requester A (data unit) request; held high until a_ack.
REQ-006 a_op  in  1  A operation: 0 = push, 1 = pop; stable while a_req is high.
REQ-007 a_data  in  STOS_data_rozm  A push data; stable while a_req is high.
REQ-008 a_ack  out  1  one-cycle completion pulse to A.
REQ-009 a_rdata  out  STOS_data_rozm  A pop result; valid with a_ack; held until the next A pop completes.
REQ-010 b_req  in  1  requester B (call/return unit) request; held high until b_ack.
REQ-011 b_op  in  1  B operation: 0 = push PC, 1 = pop PC.
REQ-012 b_pc  in  2*STOS_data_rozm  B push word.
REQ-013 b_ack  out  1  one-cycle completion pulse to B.
REQ-014 b_rpc  out  2*STOS_data_rozm  B pop word; valid with b_ack; held until the next B pop completes.
REQ-015 st_push, st_pop  out  1 each  strobes to the stack; never both high in the same cycle.
REQ-016 st_data_in  out  STOS_data_rozm  push data to the stack.
REQ-017 st_data_out  in  STOS_data_rozm  stack read data; valid combinationally in the cycle st_pop is high.
REQ-018 err_ovf, err_unf  out  1 each  sticky overflow and underflow flags.
REQ-019 err_clr  in  1  clears both sticky flags.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 occ  out  $clog2(STOS_Rozm)+1  current occupancy count.

Function
REQ-022 FSM states: IDLE, A_XFER, B_LO, B_HI, RESP.
REQ-023 IDLE: with exactly one request pending, grant it; with both pending, grant the requester not granted last (round-robin); update last_grant on every grant.
REQ-024 Feasibility is checked at grant: A push needs occ<STOS_Rozm, A pop needs occ>=1, B push needs occ<=STOS_Rozm-2, B pop needs occ>=2.
REQ-025 Infeasible grant: go directly to RESP with no stack strobe; set err_ovf (push) or err_unf (pop); ack is still issued.
REQ-026 A feasible: IDLE->A_XFER (one st_push or st_pop cycle; a_rdata registered from st_data_out on pop)->RESP.
REQ-027 B push: B_LO pushes b_pc low byte, then B_HI pushes the high byte, so the high byte ends on top.
REQ-028 B pop: B_LO pops the high byte, then B_HI pops the low byte; b_rpc is assembled in registers.
REQ-029 RESP: pulse the granted requester's ack for one cycle, then go to IDLE.
REQ-030 Latency from IDLE grant cycle to ack: A = 2 cycles, B = 3 cycles, rejected request = 1 cycle.
REQ-031 occ increments on each st_push cycle and decrements on each st_pop cycle; it saturates at 0 and STOS_Rozm.
REQ-032 Requesters deassert req in the cycle after ack; IDLE re-arbitrates on the following cycle, so there is no back-to-back grant without one IDLE cycle.
REQ-033 A sticky-flag set takes priority over err_clr in the same cycle.
REQ-034 Request inputs are ignored outside IDLE.

Reset
REQ-035 On rst: state=IDLE; occ=0; last_grant=B (A wins the first tie); all strobes, acks and error flags 0; a_rdata and b_rpc 0.
REQ-036 rst asserted mid-operation aborts the operation with no ack; the partially pushed stack content is discarded by the stack's own reset.

Structure
REQ-037 Package stos_pkg holds: the state enum, op encodings (OP_PUSH=0, OP_POP=1), and the default width and depth constants.
REQ-038 The round-robin 2-way grant logic is one sub-module, arb_rr2; the datapath and FSM stay in stos_arbiter.

Verification
REQ-039 After reset, A pushes 0x5A then A pops -> a_ack 2 cycles after each grant, a_rdata=0x5A, occ goes 0->1->0.
REQ-040 B pushes 0x1234 then B pops -> stack strobe sequence push 0x34, push 0x12, then 2 pops; b_rpc=0x1234.
REQ-041 a_req and b_req rise together, both pushes -> A is served first, then B; a repeated tie is served B first.
REQ-042 occ=31, B push -> no st_push, err_ovf=1, b_ack 1 cycle after grant; err_clr later -> err_ovf=0.
REQ-043 Empty stack, A pop -> err_unf=1, a_rdata unchanged, occ=0.
REQ-044 rst pulsed during B_HI of a B push -> no b_ack; state=IDLE, occ=0; the next A pop underflows.
